// File: rtl/pck_injct_scheduler.sv
// Round-robin arbiter sharing one packet-injector port between NS traffic sources.
// Picks a source, then a ready VC within its mask, and issues a one-cycle write/ack pulse.
module pck_injct_scheduler #(
  parameter int NS          = 4,
  parameter int V           = 4,
  parameter int PCK_SIZw    = 7,
  parameter int EAw         = 8,
  parameter int Cw          = 2,
  parameter int MIN_PCK_SIZ = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic [NS-1:0]           i_src_req,
  input  logic [NS*PCK_SIZw-1:0]  i_src_size,
  input  logic [NS*EAw-1:0]       i_src_dest,
  input  logic [NS*Cw-1:0]        i_src_class,
  input  logic [NS*V-1:0]         i_src_vc_mask,
  output logic [NS-1:0]           o_src_ack,
  output logic [NS-1:0]           o_src_err,
  input  logic [V-1:0]            i_inj_ready,
  output logic                    o_inj_pck_wr,
  output logic [V-1:0]            o_inj_vc,
  output logic [PCK_SIZw-1:0]     o_inj_size,
  output logic [EAw-1:0]          o_inj_endp_addr,
  output logic [Cw-1:0]           o_inj_class,
  output logic [$clog2(NS)-1:0]   o_inj_src_id,
  output logic [31:0]             o_pck_count,
  output logic [15:0]             o_drop_count
);

  localparam int SW = $clog2(NS);
  localparam int VW = (V > 1) ? $clog2(V) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              r_state, w_state_next;
  logic [SW-1:0]       r_src_ptr;
  logic [VW-1:0]       r_vc_ptr;
  logic [NS-1:0]       r_src_ack, r_src_err;
  logic                r_inj_pck_wr;
  logic [V-1:0]        r_inj_vc;
  logic [PCK_SIZw-1:0] r_inj_size;
  logic [EAw-1:0]      r_inj_endp_addr;
  logic [Cw-1:0]       r_inj_class;
  logic [SW-1:0]       r_inj_src_id;
  logic [31:0]         r_pck_count;
  logic [15:0]         r_drop_count;

  logic [PCK_SIZw-1:0] w_size  [NS];
  logic [EAw-1:0]      w_dest  [NS];
  logic [Cw-1:0]       w_class [NS];
  logic [V-1:0]        w_mask  [NS];
  logic [NS-1:0]       w_illegal, w_elig;
  logic [SW-1:0]       w_src_cand [NS];
  logic [VW-1:0]       w_vc_cand  [V];
  logic                w_found, w_grant, w_win_illegal;
  logic [SW-1:0]       w_win;
  logic [NS-1:0]       w_win_onehot;
  logic [V-1:0]        w_vc_avail, w_vc_onehot;
  logic [VW-1:0]       w_vc_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_src
      logic [SW:0] w_sum;
      assign w_size[gi]  = i_src_size[gi*PCK_SIZw +: PCK_SIZw];
      assign w_dest[gi]  = i_src_dest[gi*EAw +: EAw];
      assign w_class[gi] = i_src_class[gi*Cw +: Cw];
      assign w_mask[gi]  = i_src_vc_mask[gi*V +: V];
      // Illegal-size requests are drained even when no VC is ready.
      assign w_illegal[gi] = (w_size[gi] < PCK_SIZw'(MIN_PCK_SIZ)) || (w_size[gi] == '0);
      assign w_elig[gi]    = i_src_req[gi] & ((|(w_mask[gi] & i_inj_ready)) | w_illegal[gi]);
      assign w_sum = {1'b0, r_src_ptr} + (SW+1)'(gi);
      assign w_src_cand[gi] = (w_sum >= (SW+1)'(NS)) ? SW'(w_sum - (SW+1)'(NS)) : SW'(w_sum);
    end
    for (gi = 0; gi < V; gi++) begin : g_vc
      logic [VW:0] w_sum;
      assign w_sum = {1'b0, r_vc_ptr} + (VW+1)'(gi);
      assign w_vc_cand[gi] = (w_sum >= (VW+1)'(V)) ? VW'(w_sum - (VW+1)'(V)) : VW'(w_sum);
    end
  endgenerate

  always_comb begin
    w_found      = 1'b0;
    w_win        = '0;
    w_win_onehot = '0;
    for (int k = 0; k < NS; k++) begin
      if (!w_found && w_elig[w_src_cand[k]]) begin
        w_found = 1'b1;
        w_win   = w_src_cand[k];
      end
    end
    w_win_onehot[w_win] = 1'b1;
    w_win_illegal       = w_illegal[w_win];
  end

  always_comb begin
    w_vc_avail  = w_mask[w_win] & i_inj_ready;
    w_vc_idx    = '0;
    w_vc_onehot = '0;
    for (int k = V - 1; k >= 0; k--) begin
      if (w_vc_avail[w_vc_cand[k]]) w_vc_idx = w_vc_cand[k];
    end
    w_vc_onehot[w_vc_idx] = 1'b1;
  end

  assign w_grant = (r_state == IDLE) && i_enable && w_found;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_next = ISSUE;
      ISSUE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Outputs are loaded on the grant edge so the pulse lives for exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_ptr       <= '0;
      r_vc_ptr        <= '0;
      r_src_ack       <= '0;
      r_src_err       <= '0;
      r_inj_pck_wr    <= 1'b0;
      r_inj_vc        <= '0;
      r_inj_size      <= '0;
      r_inj_endp_addr <= '0;
      r_inj_class     <= '0;
      r_inj_src_id    <= '0;
      r_pck_count     <= '0;
      r_drop_count    <= '0;
    end else begin
      r_src_ack       <= '0;
      r_src_err       <= '0;
      r_inj_pck_wr    <= 1'b0;
      r_inj_vc        <= '0;
      r_inj_size      <= '0;
      r_inj_endp_addr <= '0;
      r_inj_class     <= '0;
      r_inj_src_id    <= '0;
      if (w_grant) begin
        r_src_ptr <= (w_win == SW'(NS - 1)) ? '0 : w_win + 1'b1;
        r_src_ack <= w_win_onehot;
        if (w_win_illegal) begin
          r_src_err <= w_win_onehot;
          if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        end else begin
          r_inj_pck_wr    <= 1'b1;
          r_inj_vc        <= w_vc_onehot;
          r_inj_size      <= w_size[w_win];
          r_inj_endp_addr <= w_dest[w_win];
          r_inj_class     <= w_class[w_win];
          r_inj_src_id    <= w_win;
          r_vc_ptr        <= (w_vc_idx == VW'(V - 1)) ? '0 : w_vc_idx + 1'b1;
          r_pck_count     <= r_pck_count + 32'd1;
        end
      end
    end
  end

  assign o_src_ack       = r_src_ack;
  assign o_src_err       = r_src_err;
  assign o_inj_pck_wr    = r_inj_pck_wr;
  assign o_inj_vc        = r_inj_vc;
  assign o_inj_size      = r_inj_size;
  assign o_inj_endp_addr = r_inj_endp_addr;
  assign o_inj_class     = r_inj_class;
  assign o_inj_src_id    = r_inj_src_id;
  assign o_pck_count     = r_pck_count;
  assign o_drop_count    = r_drop_count;

endmodule

// File: tb/tb_pck_injct_scheduler.sv
// Directed self-checking bench for pck_injct_scheduler; one task per scenario.
module tb_pck_injct_scheduler;
  localparam int NS = 4, V = 4, PW = 7, EAw = 8, Cw = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic [NS-1:0]       src_req = '0;
  logic [NS*PW-1:0]    src_size = '0;
  logic [NS*EAw-1:0]   src_dest = '0;
  logic [NS*Cw-1:0]    src_class = '0;
  logic [NS*V-1:0]     src_vc_mask = '0;
  logic [V-1:0]        inj_ready = '0;
  logic [NS-1:0]       src_ack, src_err;
  logic                inj_pck_wr;
  logic [V-1:0]        inj_vc;
  logic [PW-1:0]       inj_size;
  logic [EAw-1:0]      inj_endp_addr;
  logic [Cw-1:0]       inj_class;
  logic [1:0]          inj_src_id;
  logic [31:0]         pck_count;
  logic [15:0]         drop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pck_injct_scheduler #(.NS(NS), .V(V), .PCK_SIZw(PW), .EAw(EAw), .Cw(Cw), .MIN_PCK_SIZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_src_req(src_req), .i_src_size(src_size),
    .i_src_dest(src_dest), .i_src_class(src_class), .i_src_vc_mask(src_vc_mask),
    .o_src_ack(src_ack), .o_src_err(src_err), .i_inj_ready(inj_ready), .o_inj_pck_wr(inj_pck_wr),
    .o_inj_vc(inj_vc), .o_inj_size(inj_size), .o_inj_endp_addr(inj_endp_addr), .o_inj_class(inj_class),
    .o_inj_src_id(inj_src_id), .o_pck_count(pck_count), .o_drop_count(drop_count)
  );

  always @(negedge clk)
    if (rst_n && src_ack != '0)
      $display("txn: ack=%b err=%b wr=%b vc=%b size=%0d dest=%h class=%0d src=%0d",
               src_ack, src_err, inj_pck_wr, inj_vc, inj_size, inj_endp_addr, inj_class, inj_src_id);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_src(input int s, input logic [PW-1:0] sz, input logic [EAw-1:0] d,
                         input logic [Cw-1:0] c, input logic [V-1:0] m);
    src_size[s*PW +: PW]     = sz;
    src_dest[s*EAw +: EAw]   = d;
    src_class[s*Cw +: Cw]    = c;
    src_vc_mask[s*V +: V]    = m;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    src_req = '0; src_size = '0; src_dest = '0; src_class = '0; src_vc_mask = '0;
    inj_ready = '0; enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (inj_pck_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", inj_pck_wr); end
    checks++; if (src_ack !== 4'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", src_ack); end
    checks++; if (pck_count !== 32'd0) begin errors++; $display("FAIL reset_pck_count got=%0d exp=0", pck_count); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    @(posedge clk); #1;
    checks++; if (inj_vc !== 4'b0) begin errors++; $display("FAIL idle_vc got=%b exp=0000", inj_vc); end
  endtask

  task automatic test_single;
    do_reset();
    set_src(2, 7'd5, 8'h13, 2'd1, 4'b0010);
    inj_ready = 4'hF; src_req = 4'b0100;
    @(posedge clk); #1;
    checks++; if (inj_pck_wr !== 1'b1) begin errors++; $display("FAIL single_wr got=%b exp=1", inj_pck_wr); end
    checks++; if (inj_vc !== 4'b0010) begin errors++; $display("FAIL single_vc got=%b exp=0010", inj_vc); end
    checks++; if (inj_size !== 7'd5) begin errors++; $display("FAIL single_size got=%0d exp=5", inj_size); end
    checks++; if (inj_endp_addr !== 8'h13) begin errors++; $display("FAIL single_dest got=%h exp=13", inj_endp_addr); end
    checks++; if (inj_class !== 2'd1) begin errors++; $display("FAIL single_class got=%0d exp=1", inj_class); end
    checks++; if (inj_src_id !== 2'd2) begin errors++; $display("FAIL single_src_id got=%0d exp=2", inj_src_id); end
    checks++; if (src_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b exp=0100", src_ack); end
    checks++; if (src_err !== 4'b0000) begin errors++; $display("FAIL single_err got=%b exp=0000", src_err); end
    checks++; if (pck_count !== 32'd1) begin errors++; $display("FAIL single_pck_count got=%0d exp=1", pck_count); end
    src_req = '0;
    @(posedge clk); #1;
    checks++; if (inj_pck_wr !== 1'b0) begin errors++; $display("FAIL single_wr_drop got=%b exp=0", inj_pck_wr); end
    checks++; if (inj_size !== 7'd0) begin errors++; $display("FAIL single_size_clr got=%0d exp=0", inj_size); end
    checks++; if (src_ack !== 4'b0) begin errors++; $display("FAIL single_ack_clr got=%b exp=0000", src_ack); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp;
    do_reset();
    for (int s = 0; s < NS; s++) set_src(s, 7'd1, 8'(8'h40 + s), 2'(s), 4'hF);
    inj_ready = 4'hF; src_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      @(posedge clk); #1;
      checks++; if (src_ack !== exp) begin errors++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, src_ack, exp); end
      checks++; if (inj_vc !== exp) begin errors++; $display("FAIL b2b_vc[%0d] got=%b exp=%b", i, inj_vc, exp); end
      checks++; if (inj_endp_addr !== 8'(8'h40 + (i % 4))) begin errors++; $display("FAIL b2b_dest[%0d] got=%h exp=%h", i, inj_endp_addr, 8'(8'h40 + (i % 4))); end
      @(posedge clk); #1;
      checks++; if (inj_pck_wr !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d] got=%b exp=0", i, inj_pck_wr); end
    end
    src_req = '0;
    checks++; if (pck_count !== 32'd5) begin errors++; $display("FAIL b2b_pck_count got=%0d exp=5", pck_count); end
  endtask

  task automatic test_vc_wait;
    do_reset();
    set_src(0, 7'd2, 8'h20, 2'd0, 4'b0001);
    set_src(1, 7'd3, 8'h21, 2'd2, 4'b0100);
    inj_ready = 4'b1110; src_req = 4'b0011;
    @(posedge clk); #1;
    checks++; if (src_ack !== 4'b0010) begin errors++; $display("FAIL vcwait_ack1 got=%b exp=0010", src_ack); end
    checks++; if (inj_vc !== 4'b0100) begin errors++; $display("FAIL vcwait_vc1 got=%b exp=0100", inj_vc); end
    src_req = 4'b0001; inj_ready = 4'hF;
    @(posedge clk); #1;
    checks++; if (src_ack !== 4'b0000) begin errors++; $display("FAIL vcwait_gap got=%b exp=0000", src_ack); end
    @(posedge clk); #1;
    checks++; if (src_ack !== 4'b0001) begin errors++; $display("FAIL vcwait_ack0 got=%b exp=0001", src_ack); end
    checks++; if (inj_vc !== 4'b0001) begin errors++; $display("FAIL vcwait_vc0 got=%b exp=0001", inj_vc); end
    checks++; if (inj_size !== 7'd2) begin errors++; $display("FAIL vcwait_size0 got=%0d exp=2", inj_size); end
    src_req = '0;
  endtask

  task automatic test_drop;
    do_reset();
    set_src(3, 7'd0, 8'h33, 2'd3, 4'b0000);
    inj_ready = 4'b0000; src_req = 4'b1000;
    @(posedge clk); #1;
    checks++; if (src_ack !== 4'b1000) begin errors++; $display("FAIL drop_ack got=%b exp=1000", src_ack); end
    checks++; if (src_err !== 4'b1000) begin errors++; $display("FAIL drop_err got=%b exp=1000", src_err); end
    checks++; if (inj_pck_wr !== 1'b0) begin errors++; $display("FAIL drop_wr got=%b exp=0", inj_pck_wr); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count got=%0d exp=1", drop_count); end
    checks++; if (pck_count !== 32'd0) begin errors++; $display("FAIL drop_pck_count got=%0d exp=0", pck_count); end
    checks++; if (inj_endp_addr !== 8'h00) begin errors++; $display("FAIL drop_dest got=%h exp=00", inj_endp_addr); end
    src_req = '0;
    @(posedge clk); #1;
    checks++; if (src_err !== 4'b0000) begin errors++; $display("FAIL drop_err_clr got=%b exp=0000", src_err); end
  endtask

  task automatic test_enable;
    do_reset();
    enable = 1'b0;
    set_src(1, 7'd4, 8'h51, 2'd1, 4'hF);
    inj_ready = 4'hF; src_req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (src_ack !== 4'b0000) begin errors++; $display("FAIL enable_hold[%0d] got=%b exp=0000", i, src_ack); end
    end
    enable = 1'b1;
    @(posedge clk); #1;
    checks++; if (src_ack !== 4'b0010) begin errors++; $display("FAIL enable_grant got=%b exp=0010", src_ack); end
    checks++; if (pck_count !== 32'd1) begin errors++; $display("FAIL enable_pck_count got=%0d exp=1", pck_count); end
    src_req = '0;
  endtask

  task automatic test_reset_mid_issue;
    do_reset();
    set_src(0, 7'd6, 8'h60, 2'd0, 4'hF);
    set_src(2, 7'd5, 8'h62, 2'd2, 4'hF);
    inj_ready = 4'hF; src_req = 4'b0100;
    @(posedge clk); #1;
    checks++; if (inj_pck_wr !== 1'b1) begin errors++; $display("FAIL midrst_pre_wr got=%b exp=1", inj_pck_wr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (inj_pck_wr !== 1'b0) begin errors++; $display("FAIL midrst_wr got=%b exp=0", inj_pck_wr); end
    checks++; if (src_ack !== 4'b0000) begin errors++; $display("FAIL midrst_ack got=%b exp=0000", src_ack); end
    checks++; if (pck_count !== 32'd0) begin errors++; $display("FAIL midrst_pck_count got=%0d exp=0", pck_count); end
    checks++; if (inj_src_id !== 2'd0) begin errors++; $display("FAIL midrst_src_id got=%0d exp=0", inj_src_id); end
    @(negedge clk);
    rst_n = 1'b1; src_req = 4'b0101;
    @(posedge clk); #1;
    checks++; if (src_ack !== 4'b0001) begin errors++; $display("FAIL midrst_first_ack got=%b exp=0001", src_ack); end
    checks++; if (inj_size !== 7'd6) begin errors++; $display("FAIL midrst_first_size got=%0d exp=6", inj_size); end
    src_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_vc_wait();
    test_drop();
    test_enable();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
